// File: rtl/bus_arbiter.sv
// Two-master serial bus arbiter: round-robin on ties, tenure-limited grants with
// a fixed idle gap between owners and combinational routing of the serial lines.
module bus_arbiter #(
   parameter logic [15:0] MAX_TENURE = 16'd2048,
   parameter int unsigned GAP_CYCLES = 2
) (
   input  logic        clock,
   input  logic        rst_n,
   input  logic        m1_bus_req,
   input  logic        m2_bus_req,
   input  logic        m1_addr_tx,
   input  logic        m1_data_tx,
   input  logic        m1_valid_s,
   input  logic        m1_write_en,
   input  logic        m1_burst_mode,
   input  logic        m2_addr_tx,
   input  logic        m2_data_tx,
   input  logic        m2_valid_s,
   input  logic        m2_write_en,
   input  logic        m2_burst_mode,
   input  logic        slave_data_rx,
   input  logic        slave_ready,
   input  logic        slave_valid,
   output logic        m1_bus_ready,
   output logic        m2_bus_ready,
   output logic        bus_addr_tx,
   output logic        bus_data_tx,
   output logic        bus_valid_s,
   output logic        bus_write_en,
   output logic        bus_burst_mode,
   output logic        m1_data_rx,
   output logic        m1_slave_ready,
   output logic        m1_slave_valid,
   output logic        m2_data_rx,
   output logic        m2_slave_ready,
   output logic        m2_slave_valid,
   output logic [1:0]  owner,
   output logic [15:0] tenure_cnt
);

   // state  | meaning
   // IDLE   | no owner, arbitrate every cycle
   // GRANT1 | master 1 owns the bus
   // GRANT2 | master 2 owns the bus
   // GAP    | dead cycles between owners, arbitrates on its last cycle
   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] GRANT1 = 2'd1;
   localparam logic [1:0] GRANT2 = 2'd2;
   localparam logic [1:0] GAP    = 2'd3;

   localparam logic [2:0] GAP_LOAD = 3'(GAP_CYCLES - 1);

   logic [1:0]  state, state_nxt;
   logic [1:0]  arb_pick;
   logic [1:0]  last_owner, last_owner_nxt;
   logic [2:0]  gap_cnt, gap_cnt_nxt;
   logic [15:0] tenure_nxt;
   logic        tenure_hit;

   assign tenure_hit = (tenure_cnt >= MAX_TENURE);

   // Ties go to whoever was not served last.
   always_comb begin
      arb_pick = IDLE;
      if (m1_bus_req && m2_bus_req)
         arb_pick = (last_owner == 2'd1) ? GRANT2 : GRANT1;
      else if (m1_bus_req)
         arb_pick = GRANT1;
      else if (m2_bus_req)
         arb_pick = GRANT2;
   end

   always_comb begin
      state_nxt      = state;
      gap_cnt_nxt    = gap_cnt;
      last_owner_nxt = last_owner;
      case (state)
         IDLE: state_nxt = arb_pick;
         GRANT1: begin
            if (!m1_bus_req || (tenure_hit && m2_bus_req && !m1_valid_s)) begin
               state_nxt      = GAP;
               gap_cnt_nxt    = GAP_LOAD;
               last_owner_nxt = 2'd1;
            end
         end
         GRANT2: begin
            if (!m2_bus_req || (tenure_hit && m1_bus_req && !m2_valid_s)) begin
               state_nxt      = GAP;
               gap_cnt_nxt    = GAP_LOAD;
               last_owner_nxt = 2'd2;
            end
         end
         GAP: begin
            if (gap_cnt == 3'd0)
               state_nxt = arb_pick;
            else
               gap_cnt_nxt = gap_cnt - 3'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      tenure_nxt = 16'd0;
      if ((state == GRANT1 || state == GRANT2) && state_nxt == state)
         tenure_nxt = (tenure_cnt == 16'hFFFF) ? tenure_cnt : tenure_cnt + 16'd1;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         gap_cnt      <= 3'd0;
         last_owner   <= 2'd2;
         tenure_cnt   <= 16'd0;
         owner        <= 2'd0;
         m1_bus_ready <= 1'b0;
         m2_bus_ready <= 1'b0;
      end else begin
         state        <= state_nxt;
         gap_cnt      <= gap_cnt_nxt;
         last_owner   <= last_owner_nxt;
         tenure_cnt   <= tenure_nxt;
         owner        <= (state_nxt == GRANT1) ? 2'd1 : (state_nxt == GRANT2) ? 2'd2 : 2'd0;
         m1_bus_ready <= (state_nxt == GRANT1);
         m2_bus_ready <= (state_nxt == GRANT2);
      end
   end

   // Serial lines follow the registered owner with no added latency.
   always_comb begin
      bus_addr_tx    = 1'b0;
      bus_data_tx    = 1'b0;
      bus_valid_s    = 1'b0;
      bus_write_en   = 1'b0;
      bus_burst_mode = 1'b0;
      m1_data_rx     = 1'b0;
      m1_slave_ready = 1'b0;
      m1_slave_valid = 1'b0;
      m2_data_rx     = 1'b0;
      m2_slave_ready = 1'b0;
      m2_slave_valid = 1'b0;
      case (owner)
         2'd1: begin
            bus_addr_tx    = m1_addr_tx;
            bus_data_tx    = m1_data_tx;
            bus_valid_s    = m1_valid_s;
            bus_write_en   = m1_write_en;
            bus_burst_mode = m1_burst_mode;
            m1_data_rx     = slave_data_rx;
            m1_slave_ready = slave_ready;
            m1_slave_valid = slave_valid;
         end
         2'd2: begin
            bus_addr_tx    = m2_addr_tx;
            bus_data_tx    = m2_data_tx;
            bus_valid_s    = m2_valid_s;
            bus_write_en   = m2_write_en;
            bus_burst_mode = m2_burst_mode;
            m2_data_rx     = slave_data_rx;
            m2_slave_ready = slave_ready;
            m2_slave_valid = slave_valid;
         end
         default: ;
      endcase
   end

endmodule
